// File: rtl/tse_global_cfg_regfile.sv
// TSE global and per-port configuration register file.
// Decodes the local-bus register interface and drives the hardware stage, the
// per-port queue thresholds and the gate-schedule parameters. The schedule
// period and slot length are double-buffered: software writes shadow copies
// and arms a commit. The active copies then update together on the next
// schedule-period boundary. A lock bit blocks every write except the write
// that clears the lock itself.
module tse_global_cfg_regfile #(
  parameter logic [31:0] TSE_VER  = 32'h3500,
  parameter int          PORT_NUM = 8,
  parameter int          THR_W    = 9,
  parameter int          TIME_W   = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [18:0]               iv_addr,
  input  logic                      i_addr_fixed,
  input  logic [31:0]               iv_wdata,
  input  logic                      i_wr,
  input  logic                      i_rd,
  input  logic                      i_period_start,
  output logic                      o_wr,
  output logic [18:0]               ov_addr,
  output logic                      o_addr_fixed,
  output logic [31:0]               ov_rdata,
  output logic                      o_rd_err,
  output logic [31:0]               ov_tse_ver,
  output logic [2:0]                ov_hardware_stage,
  output logic [PORT_NUM*THR_W-1:0] ov_rc_threshold_value,
  output logic [PORT_NUM*THR_W-1:0] ov_be_threshold_value,
  output logic [PORT_NUM*THR_W-1:0] ov_standardpkt_threshold_value,
  output logic                      o_qbv_or_qch,
  output logic [TIME_W-1:0]         ov_schedule_period,
  output logic [TIME_W-1:0]         ov_time_slot_length,
  output logic                      o_commit_pending,
  output logic                      o_commit_done
);

  localparam logic [18:0] ADDR_QBV    = 19'd0;
  localparam logic [18:0] ADDR_PERIOD = 19'd1;
  localparam logic [18:0] ADDR_SLOT   = 19'd2;
  localparam logic [18:0] ADDR_COMMIT = 19'd3;
  localparam logic [18:0] ADDR_LOCK   = 19'd4;
  localparam logic [18:0] ADDR_STAGE  = 19'd0;

  logic [2:0]        stage_reg;
  logic              qbv_or_qch_reg;
  logic [TIME_W-1:0] shadow_period_reg;
  logic [TIME_W-1:0] shadow_slot_reg;
  logic [TIME_W-1:0] active_period_reg;
  logic [TIME_W-1:0] active_slot_reg;
  logic              pending_reg;
  logic              lock_reg;
  logic              commit_done_reg;

  logic              rd_valid_reg;
  logic [18:0]       rd_addr_reg;
  logic              rd_fixed_reg;
  logic [31:0]       rd_data_reg;
  logic              rd_err_reg;

  logic              lock_addr_hit;
  logic              wr_en;
  logic              wr_fixed;
  logic              wr_stage;
  logic              commit;
  logic              rd_fire;
  logic [31:0]       rd_data_next;
  logic              rd_err_next;

  // Only upper write-data bits beyond the widest field are left unused.
  logic              unused_wdata;
  assign unused_wdata = ^iv_wdata;

  // The lock register itself stays writable so that a locked block can be
  // unlocked again.
  assign lock_addr_hit = i_addr_fixed && (iv_addr == ADDR_LOCK);
  assign wr_en         = i_wr && (!lock_reg || lock_addr_hit);
  assign wr_fixed      = wr_en && i_addr_fixed;
  assign wr_stage      = wr_en && !i_addr_fixed && (iv_addr == ADDR_STAGE);

  // The commit condition uses the pending value from before this edge. An arm
  // that lands on the same edge as the boundary therefore waits for the next
  // boundary.
  assign commit  = i_period_start && pending_reg;

  // When a write and a read arrive together, the read is dropped.
  assign rd_fire = i_rd && !i_wr;

  // Update the global configuration, the shadow/active schedule and the commit state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_reg         <= 3'd0;
      qbv_or_qch_reg    <= 1'b1;
      shadow_period_reg <= TIME_W'(2);
      shadow_slot_reg   <= TIME_W'(4);
      active_period_reg <= TIME_W'(2);
      active_slot_reg   <= TIME_W'(4);
      pending_reg       <= 1'b0;
      lock_reg          <= 1'b0;
      commit_done_reg   <= 1'b0;
    end else begin
      commit_done_reg <= commit;
      // On a coinciding shadow write, the active copy takes the old shadow value.
      if (commit) begin
        active_period_reg <= shadow_period_reg;
        active_slot_reg   <= shadow_slot_reg;
        pending_reg       <= 1'b0;
      end
      if (wr_stage) begin
        stage_reg <= iv_wdata[2:0];
      end
      if (wr_fixed) begin
        case (iv_addr)
          ADDR_QBV:    qbv_or_qch_reg    <= iv_wdata[0];
          ADDR_PERIOD: shadow_period_reg <= iv_wdata[TIME_W-1:0];
          ADDR_SLOT:   shadow_slot_reg   <= iv_wdata[TIME_W-1:0];
          ADDR_COMMIT: pending_reg       <= iv_wdata[0];
          ADDR_LOCK:   lock_reg          <= iv_wdata[0];
          default:     ;
        endcase
      end
    end
  end

  // Per-port thresholds. Each port sits at 16 + 4p: rc at +0, be at +1 and
  // standardpkt at +2.
  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : gen_port
    localparam logic [18:0] BASE = 19'(16 + 4 * gi);

    logic [THR_W-1:0] rc_reg;
    logic [THR_W-1:0] be_reg;
    logic [THR_W-1:0] std_reg;

    // Load the threshold addressed by this write.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rc_reg  <= '0;
        be_reg  <= '0;
        std_reg <= '0;
      end else if (wr_fixed) begin
        if (iv_addr == BASE)         rc_reg  <= iv_wdata[THR_W-1:0];
        if (iv_addr == BASE + 19'd1) be_reg  <= iv_wdata[THR_W-1:0];
        if (iv_addr == BASE + 19'd2) std_reg <= iv_wdata[THR_W-1:0];
      end
    end

    assign ov_rc_threshold_value[gi*THR_W +: THR_W]          = rc_reg;
    assign ov_be_threshold_value[gi*THR_W +: THR_W]          = be_reg;
    assign ov_standardpkt_threshold_value[gi*THR_W +: THR_W] = std_reg;
  end

  // Read decode. Any address that no case matches is reported as unmapped.
  always_comb begin
    rd_data_next = 32'd0;
    rd_err_next  = 1'b1;
    if (!i_addr_fixed) begin
      if (iv_addr == ADDR_STAGE) begin
        rd_data_next = 32'(stage_reg);
        rd_err_next  = 1'b0;
      end
    end else begin
      case (iv_addr)
        ADDR_QBV:    begin rd_data_next = 32'(qbv_or_qch_reg);         rd_err_next = 1'b0; end
        ADDR_PERIOD: begin rd_data_next = 32'(shadow_period_reg);      rd_err_next = 1'b0; end
        ADDR_SLOT:   begin rd_data_next = 32'(shadow_slot_reg);        rd_err_next = 1'b0; end
        ADDR_COMMIT: begin rd_data_next = {30'd0, lock_reg, pending_reg}; rd_err_next = 1'b0; end
        ADDR_LOCK:   begin rd_data_next = 32'(lock_reg);               rd_err_next = 1'b0; end
        default: begin
          for (int i = 0; i < PORT_NUM; i++) begin
            if (iv_addr == 19'(16 + 4 * i)) begin
              rd_data_next = 32'(ov_rc_threshold_value[i*THR_W +: THR_W]);
              rd_err_next  = 1'b0;
            end
            if (iv_addr == 19'(17 + 4 * i)) begin
              rd_data_next = 32'(ov_be_threshold_value[i*THR_W +: THR_W]);
              rd_err_next  = 1'b0;
            end
            if (iv_addr == 19'(18 + 4 * i)) begin
              rd_data_next = 32'(ov_standardpkt_threshold_value[i*THR_W +: THR_W]);
              rd_err_next  = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Single-cycle read response. The response bus reads as zero in every cycle
  // without a read.
  always_ff @(posedge i_clk) begin
    if (i_rst || !rd_fire) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= 19'd0;
      rd_fixed_reg <= 1'b0;
      rd_data_reg  <= 32'd0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b1;
      rd_addr_reg  <= iv_addr;
      rd_fixed_reg <= i_addr_fixed;
      rd_data_reg  <= rd_data_next;
      rd_err_reg   <= rd_err_next;
    end
  end

  assign o_wr                = rd_valid_reg;
  assign ov_addr             = rd_addr_reg;
  assign o_addr_fixed        = rd_fixed_reg;
  assign ov_rdata            = rd_data_reg;
  assign o_rd_err            = rd_err_reg;
  assign ov_tse_ver          = TSE_VER;
  assign ov_hardware_stage   = stage_reg;
  assign o_qbv_or_qch        = qbv_or_qch_reg;
  assign ov_schedule_period  = active_period_reg;
  assign ov_time_slot_length = active_slot_reg;
  assign o_commit_pending    = pending_reg;
  assign o_commit_done       = commit_done_reg;

endmodule

// File: doc/tse_global_cfg_regfile.md
# tse_global_cfg_regfile

Parametrised global and per-port configuration register file for the TSE (TSN switch engine), the successor to the single-port global register block. It decodes the local-bus register write/read interface and drives hardware stage, per-port queue thresholds and gate-schedule parameters. Schedule parameters are double-buffered: they are written to shadow registers and committed atomically to the active outputs on a schedule-period boundary. A lock bit write-protects the configuration.

## Interface
- TSE_VER, 32'h3500: constant version value driven on ov_tse_ver.
- PORT_NUM, 8: number of ports with per-port thresholds, 1..32.
- THR_W, 9: threshold width.
- TIME_W, 11: schedule period and slot-length width.

- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- iv_addr  in  19  register address.
- i_addr_fixed  in  1  1 = fixed (global/port) space, 0 = stage space.
- iv_wdata  in  32  write data.
- i_wr  in  1  write strobe, single cycle.
- i_rd  in  1  read strobe, single cycle.
- i_period_start  in  1  one-cycle pulse at each schedule-period boundary.
- o_wr  out  1  read-response valid.
- ov_addr  out  19  echoed read address.
- o_addr_fixed  out  1  echoed address space.
- ov_rdata  out  32  read data, zero-extended.
- o_rd_err  out  1  read response for an unmapped address.
- ov_tse_ver  out  32  equals TSE_VER.
- ov_hardware_stage  out  3  stage.
- ov_rc_threshold_value / ov_be_threshold_value / ov_standardpkt_threshold_value  out  PORT_NUM*THR_W each  per-port thresholds, port p at [p*THR_W +: THR_W].
- o_qbv_or_qch  out  1  1 = Qch, 0 = Qbv.
- ov_schedule_period / ov_time_slot_length  out  TIME_W each  active schedule values.
- o_commit_pending  out  1  commit armed, not yet applied.
- o_commit_done  out  1  one-cycle pulse when active values update.

## Operation
- Address map, stage space (i_addr_fixed=0): addr 0 = hardware_stage[2:0]. Every other address is unmapped.
- Address map, fixed space:
  - 0 = qbv_or_qch[0].
  - 1 = shadow schedule_period.
  - 2 = shadow time_slot_length.
  - 3 = commit: write bit0=1 arms. Read returns {30'b0, lock, pending}.
  - 4 = lock[0].
  - 16+4p+{0,1,2} = port p rc/be/standardpkt threshold, for p < PORT_NUM.
  - Every other address is unmapped.
- Writes:
  - Written data is truncated to the field width.
  - Writes to unmapped addresses are ignored.
  - While lock=1, every write except to address 4 is ignored, including commit arm.
- Reads:
  - A read of address 1 or 2 returns the shadow value, not the active value.
  - A read of an unmapped address gives o_wr=1, o_rd_err=1, ov_rdata=0.
- Commit:
  - Writing 1 to bit0 of address 3 sets pending.
  - On the next i_period_start with pending=1, active period and slot take the shadow values, pending clears, and o_commit_done pulses.
  - Writing 0 to bit0 of address 3 clears pending (cancels the commit).
  - Shadow writes while pending=1 are allowed; the latest shadow value is the one committed.
- Simultaneous i_wr and i_rd: the write is performed and the read is dropped (no response).

## Timing
- Reset values:
  - stage 0; all thresholds 0; qbv_or_qch 1.
  - Shadow and active period = 2; shadow and active slot = 4.
  - pending 0, lock 0.
  - o_wr, ov_addr, o_addr_fixed, ov_rdata, o_rd_err, o_commit_done all 0.
- Write latency: the register updates at the clock edge sampling i_wr and is visible on its output the next cycle.
- Read latency: the response appears exactly 1 cycle after i_rd and is held for 1 cycle only. In every cycle without a read, o_wr, ov_addr, o_addr_fixed, ov_rdata and o_rd_err are all 0.
- Arm coinciding with i_period_start (same cycle): no commit that cycle. pending becomes 1 and the commit occurs at the following i_period_start.
- i_period_start with pending=0: no effect.
- The commit edge updates ov_schedule_period and ov_time_slot_length, and asserts o_commit_done in the same cycle they change.
- Shadow write coinciding with the commit edge: the active register takes the pre-write shadow value; the new write lands in shadow only.
- Reset asserted while pending: pending clears and the active values return to their reset values; no o_commit_done.

## Test plan
- Reset, then read every mapped address → values as listed under reset, ov_tse_ver=32'h3500, each response 1 cycle after i_rd.
- Write fixed 16+4*3+1 = 0x1AB (port 3 be) → ov_be_threshold_value[35:27]=0x1AB, other ports 0. Read back → ov_rdata=0x1AB.
- Write fixed 1 = 100, fixed 2 = 7, fixed 3 = 1 → active values stay 2/4 and pending=1. Pulse i_period_start → active 100/7, o_commit_done for 1 cycle, pending=0.
- Arm in the same cycle as i_period_start → no update. Next i_period_start → update.
- Write fixed 4 = 1, then write fixed 0 = 0 → o_qbv_or_qch stays 1. Write fixed 4 = 0, retry → o_qbv_or_qch becomes 0.
- Read fixed 0x7FFFF and stage-space addr 1 → o_wr=1, o_rd_err=1, ov_rdata=0. Simultaneous i_wr+i_rd to fixed 0 → write applied, o_wr stays 0.
